// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled 2-of-3 majority bit recovery with
// optional even/odd parity check and stop-bit check.
module uart_rx_deserializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clck,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_W-1:0]     p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);
  localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0]     shreg;
  logic [2:0]            samp;
  logic                  par_en_l;
  logic                  par_typ_l;
  logic                  par_bad;
  logic                  par_bad_nxt;
  logic                  valid_nxt;
  logic                  perr_nxt;
  logic                  serr_nxt;
  logic                  bit_end_c;
  logic                  maj_c;
  logic                  start_c;

  assign half      = prescale >> 1;
  assign bit_end_c = (edge_cnt == prescale - PRESCALE_W'(1));
  assign maj_c     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign start_c   = (state == IDLE) && !rx_in;

  // State register
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and frame-end flag decode
  always_comb begin
    state_nxt   = state;
    par_bad_nxt = par_bad;
    valid_nxt   = 1'b0;
    perr_nxt    = 1'b0;
    serr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_in) begin
          state_nxt   = START;
          par_bad_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_end_c) state_nxt = maj_c ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end_c && (bit_cnt == BIT_CNT_W'(DATA_W - 1)))
          state_nxt = par_en_l ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end_c) begin
          state_nxt   = STOP;
          par_bad_nxt = (maj_c != ((^shreg) ^ par_typ_l));
        end
      end
      STOP: begin
        if (bit_end_c) begin
          state_nxt = IDLE;
          serr_nxt  = !maj_c;
          perr_nxt  = par_bad;
          valid_nxt = maj_c && !par_bad;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, samplers, shift register and registered outputs
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      samp       <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_bad    <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      data_valid <= valid_nxt;
      par_err    <= perr_nxt;
      stp_err    <= serr_nxt;
      if (valid_nxt) p_data <= shreg;
      if (state == IDLE) begin
        // The detection edge counts as edge 0 of the start bit
        edge_cnt <= start_c ? PRESCALE_W'(1) : '0;
        bit_cnt  <= '0;
        if (start_c) begin
          par_en_l  <= par_en;
          par_typ_l <= par_typ;
        end
      end else begin
        edge_cnt <= bit_end_c ? '0 : edge_cnt + PRESCALE_W'(1);
        if (edge_cnt == half - PRESCALE_W'(1)) samp[0] <= rx_in;
        if (edge_cnt == half)                  samp[1] <= rx_in;
        if (edge_cnt == half + PRESCALE_W'(1)) samp[2] <= rx_in;
        if (bit_end_c && (state == DATA)) begin
          shreg   <= {maj_c, shreg[DATA_W-1:1]};
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed frames plus random
// frames checked against a frame-level model of outcome, timing and p_data.
module tb_uart_rx_deserializer;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PRESCALE_W = 6;

  logic                  clck = 1'b0;
  logic                  rst;
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_W-1:0]     p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int last_pcyc;
  logic [7:0] exp_pdata = 8'h00;

  uart_rx_deserializer #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
    .clck(clck), .rst(rst), .rx_in(rx_in), .prescale(prescale),
    .par_en(par_en), .par_typ(par_typ), .p_data(p_data),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clck = ~clck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clck);
    #1;
    cyc++;
  endtask

  // Drives one frame starting at the next edge (edge k) and checks its outcome.
  // gidx: cycle offset of a one-cycle inverted glitch (-1 none).
  // abort_at: stop driving after this many cycles, without checks (-1 full frame).
  task automatic send_frame(input string tag, input int p, input bit pe, input bit pt,
                            input logic [7:0] d, input bit flip, input bit stop_v,
                            input int gidx, input int abort_at);
    logic bits [0:10];
    int   n, pulses, pidx;
    logic pdv, ppe, pse;
    bit   exp_valid;
    n = 10 + int'(pe);
    bits[0] = 1'b0;
    for (int b = 0; b < 8; b++) bits[1+b] = d[b];
    if (pe) bits[9] = 1'(($countones(d) + int'(pt) + int'(flip)) % 2);
    bits[n-1] = stop_v;
    prescale = PRESCALE_W'(p);
    par_en   = pe;
    par_typ  = pt;
    pulses = 0; pidx = -1; pdv = 1'b0; ppe = 1'b0; pse = 1'b0;
    for (int i = 0; i < n * p; i++) begin
      if (abort_at >= 0 && i >= abort_at) return;
      rx_in = bits[i / p];
      if (i == gidx) rx_in = ~rx_in;
      step();
      if ((data_valid | par_err | stp_err) !== 1'b0) begin
        pulses++;
        pidx = i; pdv = data_valid; ppe = par_err; pse = stp_err;
        last_pcyc = cyc;
      end
    end
    exp_valid = !flip && stop_v;
    if (exp_valid) exp_pdata = d;
    chk({tag, " pulses"}, 32'(pulses), 32'd1);
    chk({tag, " pulse_time"}, 32'(pidx), 32'(n * p - 1));
    chk({tag, " data_valid"}, {31'd0, pdv}, {31'd0, exp_valid});
    chk({tag, " par_err"}, {31'd0, ppe}, {31'd0, flip});
    chk({tag, " stp_err"}, {31'd0, pse}, {31'd0, !stop_v});
    chk({tag, " p_data"}, {24'd0, p_data}, {24'd0, exp_pdata});
  endtask

  initial begin
    int c1;
    int pulses;
    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) step();
    chk("reset data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset par_err", {31'd0, par_err}, 32'd0);
    chk("reset stp_err", {31'd0, stp_err}, 32'd0);
    chk("reset p_data", {24'd0, p_data}, 32'd0);
    rst = 1'b1;
    repeat (2) step();

    send_frame("p8_nopar_a5", 8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, -1);
    send_frame("p16_even_ok", 16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, -1);
    send_frame("p16_even_bad", 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, -1);
    send_frame("p32_odd_ok", 32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, -1, -1);
    send_frame("p32_odd_bad", 32, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, -1, -1);
    send_frame("p8_stop_err", 8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, -1, -1);
    send_frame("p8_recover", 8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, -1, -1);
    send_frame("p8_both_err", 8, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, -1, -1);

    // Two-cycle start glitch: no output, back in IDLE for a start at k+8
    rx_in = 1'b1; step();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      rx_in = (i < 2) ? 1'b0 : 1'b1;
      step();
      if ((data_valid | par_err | stp_err) !== 1'b0) pulses++;
    end
    chk("start_glitch pulses", 32'(pulses), 32'd0);
    send_frame("after_glitch", 8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, -1, -1);
    send_frame("data_glitch_ff", 8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 36, -1);

    // Reset after four data bits
    rx_in = 1'b1; step();
    send_frame("abort", 8, 1'b0, 1'b0, 8'hAB, 1'b0, 1'b1, -1, 40);
    rst = 1'b0;
    #1;
    chk("midreset data_valid", {31'd0, data_valid}, 32'd0);
    chk("midreset par_err", {31'd0, par_err}, 32'd0);
    chk("midreset stp_err", {31'd0, stp_err}, 32'd0);
    chk("midreset p_data", {24'd0, p_data}, 32'd0);
    exp_pdata = 8'h00;
    rx_in = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    send_frame("post_reset_c3", 8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1, -1);

    // Back-to-back with no idle gap
    send_frame("b2b_12", 16, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, -1, -1);
    c1 = last_pcyc;
    send_frame("b2b_34", 16, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, -1, -1);
    chk("b2b spacing", 32'(last_pcyc - c1), 32'd160);

    // Random frames
    for (int r = 0; r < 30; r++) begin
      int   p, n, g, gap;
      bit   pe, pt, fl, sv;
      logic [7:0] d;
      p   = 8 << $urandom_range(0, 2);
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      fl  = pe && ($urandom_range(0, 3) == 0);
      sv  = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      n   = 10 + int'(pe);
      g   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(p, n * p - 1)) : -1;
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) begin
        rx_in = 1'b1;
        step();
      end
      send_frame($sformatf("rand%0d", r), p, pe, pt, d, fl, sv, g, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
